div_req_ctrl: RTL and testbench

Request-side sequencer for the 16-bit shift/subtract divider. It accepts an operand pair over a valid/ready request port and drives the divider's `start`. It waits for the divider's `done`, captures quotient and remainder, and returns them over a valid/ready response port. It also handles divide-by-zero locally, enforces a timeout, and waits out the divider's stretched `done` pulse before issuing the next `start`.

---
 rtl/div_req_ctrl_if.sv | 42 ++++
 rtl/div_req_ctrl.sv | 129 ++++++++++++
 tb/tb_div_req_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_req_ctrl_if.sv
// Request/response handshake bundle for div_req_ctrl.
// slave = sequencer side, master = requester/consumer side.
interface div_req_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_dbz;
  logic             rsp_timeout;

  modport slave (
    input  req_valid,
    input  req_dividend,
    input  req_divisor,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_quotient,
    output rsp_remainder,
    output rsp_dbz,
    output rsp_timeout
  );

  modport master (
    output req_valid,
    output req_dividend,
    output req_divisor,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_quotient,
    input  rsp_remainder,
    input  rsp_dbz,
    input  rsp_timeout
  );
endinterface

// File: rtl/div_req_ctrl.sv
// Request-side sequencer for the shift/subtract divider:
// launch, wait with timeout, respond, drain stale done.
module div_req_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  div_req_ctrl_if.slave    bus,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             tmo_q, tmo_d;

  // Next-state, counter and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    tmo_d   = tmo_q;
    cnt_inc = cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          opa_d = bus.req_dividend;
          opb_d = bus.req_divisor;
          if (bus.req_divisor == '0) begin
            // Zero divisor is answered locally.
            quo_d   = '1;
            rem_d   = bus.req_dividend;
            dbz_d   = 1'b1;
            tmo_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // done has priority over a coincident timeout
        if (div_done) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = DRAIN;
      end
      DRAIN: begin
        // A stretched done must fall before relaunching.
        if (!div_done) state_d = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DRAIN;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_quotient  = quo_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_dbz       = dbz_q;
  assign bus.rsp_timeout   = tmo_q;
  assign div_start         = (state_q == LAUNCH);
  assign div_dividend      = opa_q;
  assign div_divisor       = opb_q;
endmodule

// File: tb/tb_div_req_ctrl.sv
// Self-checking bench for div_req_ctrl with a
// behavioural divider model and arithmetic reference.
module tb_div_req_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_done = 1'b0;
  logic [15:0] div_quotient = '0;
  logic [15:0] div_remainder = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_start = 0;

  div_req_ctrl_if #(.WIDTH(16)) bus ();

  div_req_ctrl #(.WIDTH(16), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  // Divider model: done m_dly cycles after start,
  // held m_hold_len cycles; m_never suppresses done.
  logic m_never = 1'b0;
  int   m_dly = 12;
  int   m_hold_len = 10;
  int   m_wait = 0;
  int   m_hold = 0;

  always @(posedge clk) begin
    if (m_hold > 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1) div_done <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        div_done <= 1'b1;
        m_hold   <= m_hold_len;
      end
    end
    if (div_start && !m_never) begin
      m_wait        <= m_dly;
      div_quotient  <= div_dividend / div_divisor;
      div_remainder <= div_dividend % div_divisor;
    end
  end

  always @(posedge clk) if (div_start) n_start++;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // Cycle-level invariants
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_and_valid",
          {31'd0, bus.req_ready & bus.rsp_valid}, 0);
      chk("start_while_done",
          {31'd0, div_start & div_done}, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a,
                      input logic [15:0] b);
    int t = 0;
    bus.req_valid    = 1'b1;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    while (!bus.req_ready && t < 300) begin
      tick();
      t++;
    end
    chk("send_bound", {31'd0, t < 300}, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic recv(input logic [15:0] ea,
                      input logic [15:0] eb,
                      input logic [15:0] eq,
                      input logic [15:0] er,
                      input logic edbz,
                      input logic eto,
                      input int dly);
    int t = 0;
    while (!bus.rsp_valid && t < 300) begin
      tick();
      t++;
    end
    chk("recv_bound", {31'd0, t < 300}, 1);
    for (int i = 0; i <= dly; i++) begin
      chk("rsp_valid", {31'd0, bus.rsp_valid}, 1);
      chk("rsp_q", {16'd0, bus.rsp_quotient}, {16'd0, eq});
      chk("rsp_r", {16'd0, bus.rsp_remainder}, {16'd0, er});
      chk("rsp_dbz", {31'd0, bus.rsp_dbz}, {31'd0, edbz});
      chk("rsp_to", {31'd0, bus.rsp_timeout}, {31'd0, eto});
      chk("opa_held", {16'd0, div_dividend}, {16'd0, ea});
      chk("opb_held", {16'd0, div_divisor}, {16'd0, eb});
      if (i < dly) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int s0;
    logic [15:0] a, b, eq, er;
    logic edbz, eto;

    tbl[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0};
    tbl[1] = '{16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1};
    tbl[2] = '{16'd65535, 16'd255, 16'd257, 16'd0, 1'b0};
    tbl[3] = '{16'd9, 16'd3, 16'd3, 16'd0, 1'b0};
    tbl[4] = '{16'd10, 16'd4, 16'd2, 16'd2, 1'b0};
    tbl[5] = '{16'd0, 16'd5, 16'd0, 16'd0, 1'b0};
    tbl[6] = '{16'd5, 16'd9, 16'd0, 16'd5, 1'b0};
    tbl[7] = '{16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0};
    tbl[8] = '{16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b1};
    tbl[9] = '{16'd1000, 16'd33, 16'd30, 16'd10, 1'b0};

    bus.req_valid    = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_req_ready", {31'd0, bus.req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_q", {16'd0, bus.rsp_quotient}, 0);
    chk("rst_r", {16'd0, bus.rsp_remainder}, 0);
    chk("rst_start", {31'd0, div_start}, 0);
    rst = 1'b1;
    tick();
    chk("idle_after_rst", {31'd0, bus.req_ready}, 1);

    // Table-driven vectors with latency checks
    foreach (tbl[i]) begin
      s0 = n_start;
      send(tbl[i].a, tbl[i].b);
      if (tbl[i].dbz) begin
        chk("dbz_latency", {31'd0, bus.rsp_valid}, 1);
        chk("dbz_no_start", {31'd0, div_start}, 0);
      end else begin
        chk("start_latency", {31'd0, div_start}, 1);
        t = 0;
        while (!div_done && t < 100) begin
          tick();
          t++;
        end
        chk("done_bound", {31'd0, t < 100}, 1);
        chk("valid_before", {31'd0, bus.rsp_valid}, 0);
        tick();
        chk("valid_after_done", {31'd0, bus.rsp_valid}, 1);
      end
      recv(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
           tbl[i].dbz, 1'b0, 0);
      chk("start_count", n_start - s0,
          tbl[i].dbz ? 0 : 1);
    end

    // Timeout: divider never answers
    m_never = 1'b1;
    send(16'd1000, 16'd3);
    t = 0;
    while (!bus.rsp_valid && t < 200) begin
      tick();
      t++;
    end
    chk("timeout_latency", t, 65);
    chk("timeout_flag", {31'd0, bus.rsp_timeout}, 1);
    chk("timeout_q", {16'd0, bus.rsp_quotient}, 0);
    chk("timeout_r", {16'd0, bus.rsp_remainder}, 0);
    chk("timeout_dbz", {31'd0, bus.rsp_dbz}, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("to_drain", {31'd0, bus.req_ready}, 0);
    tick();
    chk("to_ready_back", {31'd0, bus.req_ready}, 1);
    m_never = 1'b0;

    // Backpressure with second request held
    s0 = n_start;
    send(16'd65535, 16'd255);
    bus.req_valid    = 1'b1;
    bus.req_dividend = 16'd300;
    bus.req_divisor  = 16'd10;
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      tick();
      t++;
    end
    chk("bp_bound", {31'd0, t < 100}, 1);
    for (int i = 0; i < 15; i++) begin
      chk("bp_valid", {31'd0, bus.rsp_valid}, 1);
      chk("bp_q", {16'd0, bus.rsp_quotient}, 257);
      chk("bp_r", {16'd0, bus.rsp_remainder}, 0);
      chk("bp_no_accept", {31'd0, bus.req_ready}, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_drain", {31'd0, bus.req_ready}, 0);
    chk("bp_single_rsp", {31'd0, bus.rsp_valid}, 0);
    chk("bp_one_start", n_start - s0, 1);
    tick();
    chk("bp_ready", {31'd0, bus.req_ready}, 1);
    tick();
    chk("bp_second_start", {31'd0, div_start}, 1);
    bus.req_valid = 1'b0;
    recv(16'd300, 16'd10, 16'd30, 16'd0, 1'b0, 1'b0, 0);

    // Back-to-back with rsp_ready tied high
    bus.rsp_ready = 1'b1;
    send(16'd9, 16'd3);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      tick();
      t++;
    end
    chk("b2b_bound1", {31'd0, t < 100}, 1);
    chk("b2b_q1", {16'd0, bus.rsp_quotient}, 3);
    chk("b2b_r1", {16'd0, bus.rsp_remainder}, 0);
    bus.req_valid    = 1'b1;
    bus.req_dividend = 16'd10;
    bus.req_divisor  = 16'd4;
    tick();
    chk("b2b_taken", {31'd0, bus.rsp_valid}, 0);
    t = 0;
    while (div_done && t < 100) begin
      chk("b2b_hold", {31'd0, bus.req_ready}, 0);
      tick();
      t++;
    end
    chk("b2b_done_bound", {31'd0, t < 100}, 1);
    chk("b2b_still_drain", {31'd0, bus.req_ready}, 0);
    tick();
    chk("b2b_ready", {31'd0, bus.req_ready}, 1);
    tick();
    chk("b2b_start2", {31'd0, div_start}, 1);
    bus.req_valid = 1'b0;
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      tick();
      t++;
    end
    chk("b2b_bound2", {31'd0, t < 100}, 1);
    chk("b2b_q2", {16'd0, bus.rsp_quotient}, 2);
    chk("b2b_r2", {16'd0, bus.rsp_remainder}, 2);
    tick();
    bus.rsp_ready = 1'b0;
    chk("b2b_one_rsp", {31'd0, bus.rsp_valid}, 0);

    // Reset while divider is mid-operation
    send(16'd100, 16'd7);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("mr_req_ready", {31'd0, bus.req_ready}, 0);
    chk("mr_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("mr_q", {16'd0, bus.rsp_quotient}, 0);
    chk("mr_r", {16'd0, bus.rsp_remainder}, 0);
    chk("mr_dbz", {31'd0, bus.rsp_dbz}, 0);
    chk("mr_to", {31'd0, bus.rsp_timeout}, 0);
    chk("mr_start", {31'd0, div_start}, 0);
    chk("mr_opa", {16'd0, div_dividend}, 0);
    chk("mr_opb", {16'd0, div_divisor}, 0);
    t = 0;
    while (!div_done && t < 100) begin
      tick();
      t++;
    end
    chk("mr_done_bound", {31'd0, t < 100}, 1);
    rst = 1'b1;
    t = 0;
    while (div_done && t < 100) begin
      chk("mr_drain_rdy", {31'd0, bus.req_ready}, 0);
      chk("mr_drain_vld", {31'd0, bus.rsp_valid}, 0);
      tick();
      t++;
    end
    chk("mr_fall_bound", {31'd0, t < 100}, 1);
    chk("mr_last_drain", {31'd0, bus.req_ready}, 0);
    tick();
    chk("mr_idle", {31'd0, bus.req_ready}, 1);
    send(16'd50, 16'd5);
    recv(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 0);

    // Randomized traffic against arithmetic reference
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 7) == 0)
        b = 16'd0;
      else if ($urandom_range(0, 1) == 1)
        b = 16'($urandom_range(1, 20));
      else
        b = 16'($urandom_range(1, 65535));
      eto = (b != 0) && ($urandom_range(0, 9) == 0);
      m_never    = eto;
      m_dly      = $urandom_range(1, 20);
      m_hold_len = $urandom_range(1, 12);
      edbz = (b == 0);
      if (edbz) begin
        eq = 16'hFFFF;
        er = a;
      end else if (eto) begin
        eq = 16'd0;
        er = 16'd0;
      end else begin
        eq = a / b;
        er = a % b;
      end
      send(a, b);
      recv(a, b, eq, er, edbz, eto,
           $urandom_range(0, 4));
    end
    m_never = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
